// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants for the EX-stage forwarding/hazard control and the operand muxes it steers.
package forwarding_hazard_unit_pkg;

    localparam int RB_DEF = 5;
    localparam int CW_DEF = 16;

    localparam logic [RB_DEF-1:0] REG_ZERO = '0;

    typedef logic [1:0] sel_t;

    // Operand mux select codes; code 3 is unused and never produced.
    localparam sel_t SEL_RF    = 2'd0;
    localparam sel_t SEL_EXMEM = 2'd1;
    localparam sel_t SEL_MEMWB = 2'd2;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage request and EX-stage forwarding/stall response bundle.
interface forwarding_hazard_unit_if #(
    parameter int RB = 5,
    parameter int CW = 16
);
    logic          id_valid;
    logic [RB-1:0] id_rs;
    logic [RB-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [RB-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          flush;

    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic          stall;
    logic          pc_write_en;
    logic          ifid_write_en;
    logic          idex_bubble;
    logic [CW-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, flush,
        input  sel_a, sel_b, stall, pc_write_en, ifid_write_en, idex_bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, flush,
        output sel_a, sel_b, stall, pc_write_en, ifid_write_en, idex_bubble, stall_count
    );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_match.sv
// Producer/consumer compare for one source operand: picks which pipeline stage supplies it.
module fwd_match
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int RB = RB_DEF
) (
    input  logic [RB-1:0] srcReg,
    input  logic          usesSrc,
    input  logic [RB-1:0] exRd,
    input  logic          exWr,
    input  logic [RB-1:0] memRd,
    input  logic          memWr,
    output sel_t          sel
);
    logic exHit;
    logic memHit;

    // r0 is hardwired to zero, so a write to it never forwards.
    assign exHit  = usesSrc && exWr  && (exRd  != RB'(REG_ZERO)) && (exRd  == srcReg);
    assign memHit = usesSrc && memWr && (memRd != RB'(REG_ZERO)) && (memRd == srcReg);

    // EX holds the younger result, so it wins when both stages write the register.
    always_comb begin
        sel = SEL_RF;
        if (exHit) begin
            sel = SEL_EXMEM;
        end else if (memHit) begin
            sel = SEL_MEMWB;
        end
    end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks EX/MEM destination registers, registers operand mux selects as each
// instruction enters EX, and raises the load-use stall.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int RB = RB_DEF,
    parameter int CW = CW_DEF
) (
    input logic                     clk,
    input logic                     reset,
    forwarding_hazard_unit_if.slave bus
);
    logic [RB-1:0] exRd;
    logic          exWr;
    logic          exLoad;
    logic [RB-1:0] memRd;
    logic          memWr;

    sel_t          selA;
    sel_t          selB;
    sel_t          matchA;
    sel_t          matchB;
    logic [CW-1:0] stallCount;

    logic          loadHazard;
    logic          stall;
    logic          advance;

    fwd_match #(.RB(RB)) uMatchA (
        .srcReg (bus.id_rs),
        .usesSrc(bus.id_uses_rs),
        .exRd   (exRd),
        .exWr   (exWr),
        .memRd  (memRd),
        .memWr  (memWr),
        .sel    (matchA)
    );

    fwd_match #(.RB(RB)) uMatchB (
        .srcReg (bus.id_rt),
        .usesSrc(bus.id_uses_rt),
        .exRd   (exRd),
        .exWr   (exWr),
        .memRd  (memRd),
        .memWr  (memWr),
        .sel    (matchB)
    );

    // A load in EX cannot forward yet; the consumer waits one cycle and then picks it up from MEM.
    assign loadHazard = exLoad && exWr && (exRd != RB'(REG_ZERO)) &&
                        ((bus.id_uses_rs && (exRd == bus.id_rs)) ||
                         (bus.id_uses_rt && (exRd == bus.id_rt)));
    assign stall   = bus.id_valid && !bus.flush && loadHazard;
    assign advance = bus.id_valid && !stall && !bus.flush;

    // Shadow of the EX and MEM destination fields; anything not advancing enters EX as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exRd   <= '0;
            exWr   <= 1'b0;
            exLoad <= 1'b0;
            memRd  <= '0;
            memWr  <= 1'b0;
        end else begin
            memRd <= exRd;
            memWr <= exWr;
            if (advance) begin
                exRd   <= bus.id_rd;
                exWr   <= bus.id_reg_write;
                exLoad <= bus.id_mem_read;
            end else begin
                exRd   <= '0;
                exWr   <= 1'b0;
                exLoad <= 1'b0;
            end
        end
    end

    // Selects are captured alongside the instruction entering EX; bubbles read the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            selA <= SEL_RF;
            selB <= SEL_RF;
        end else if (advance) begin
            selA <= matchA;
            selB <= matchB;
        end else begin
            selA <= SEL_RF;
            selB <= SEL_RF;
        end
    end

    // Stall-cycle counter for performance debug; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall && (stallCount != '1)) begin
            stallCount <= stallCount + CW'(1);
        end
    end

    assign bus.sel_a         = selA;
    assign bus.sel_b         = selB;
    assign bus.stall         = stall;
    assign bus.pc_write_en   = !stall;
    assign bus.ifid_write_en = !stall;
    assign bus.idex_bubble   = stall || bus.flush;
    assign bus.stall_count   = stallCount;
endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control stage directly upstream of the two EX-stage operand muxes (3-in/1-out, Sel 2 bits, DB=32) in the 5-stage MIPS pipeline.
- Tracks destination registers of the instructions in EX and MEM.
- Produces registered Sel codes for operand A (rs) and operand B (rt) as each instruction enters EX, plus load-use stall control for PC, IF/ID and ID/EX.
- Keeps a saturating stall counter for performance debug.

Parameters:
- RB, 5, register address width.
- CW, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RB  source register A of the ID instruction.
- id_rt  in  RB  source register B of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_rd  in  RB  destination register of the ID instruction, already muxed rt/rd.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  squash the ID instruction (taken branch/jump).
- sel_a  out  2  Sel for operand-A mux; 0=regfile (DatoA), 1=EX/MEM (DatoB), 2=MEM/WB (DatoC).
- sel_b  out  2  Sel for operand-B mux, same encoding.
- stall  out  1  load-use stall, combinational.
- pc_write_en  out  1  equals ~stall.
- ifid_write_en  out  1  equals ~stall.
- idex_bubble  out  1  equals stall | flush; ID/EX loads a NOP.
- stall_count  out  CW  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, active-high):
  - ex_rd, ex_wr, ex_load, mem_rd, mem_wr cleared.
  - sel_a = sel_b = 0, stall_count = 0.
  - stall therefore evaluates to 0, pc_write_en = ifid_write_en = 1, idex_bubble = flush.
- Shadow pipeline (every rising edge):
  - mem_* <= ex_*, always.
  - ex_* <= ID fields if id_valid & ~stall & ~flush; otherwise bubble (ex_wr = 0, ex_load = 0, ex_rd = 0).
- Match rule: a producer matches source r only if its wr = 1, its rd != 0, rd == r, and the corresponding uses bit is 1. Register 0 never forwards.
- Sel computation, registered on the edge where the ID instruction advances:
  - sel_x <= 1 if the current EX producer matches.
  - else sel_x <= 2 if the current MEM producer matches.
  - else sel_x <= 0.
  - EX has priority over MEM (youngest value wins).
- Sel on bubble: when ex_* loads a bubble (stall, flush, or ~id_valid), sel_a and sel_b <= 0.
- Sel code 3 is never emitted.
- Stall (combinational) = id_valid & ~flush & ex_load & ex_wr & (ex_rd != 0) & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
  - Exactly one stall cycle per load-use.
  - The next cycle the load sits in MEM, so the consumer gets Sel 2.
- Flush beats stall: flush = 1 forces stall = 0 and a bubble.
- WB producers need no forwarding: the register file writes before it reads in the same cycle.
- stall_count increments on each edge with stall = 1 and saturates at all-ones (no wrap).
- Reset mid-stall: stall drops immediately (asynchronous), and the shadow state is lost by design.

Decomposition:
- Shared package holds:
  - SEL_RF = 2'd0, SEL_EXMEM = 2'd1, SEL_MEMWB = 2'd2 (shared with the mux instantiation site).
  - RB default and the REG_ZERO constant.
- One natural sub-module: fwd_match (combinational producer/consumer compare yielding a 2-bit Sel). It is instantiated twice, once for rs and once for rt.

Test Plan:
- ALU back-to-back: add r3 then sub r5,r3,r4 -> second instruction in EX sees sel_a = 1, sel_b = 0, stall never 1.
- Distance 2: add r3; nop; or r6,r3,r3 -> sel_a = sel_b = 2.
- Both stages match: add r3; add r3; and r7,r3,r0 -> sel_a = 1 (EX priority), sel_b = 0 (r0).
- Load-use: lw r2; add r4,r2,r1 -> stall = 1 for exactly one cycle, pc_write_en = 0, idex_bubble = 1; then the add enters EX with sel_a = 2; stall_count = 1.
- Flush during load-use: same pair with flush = 1 on the add's ID cycle -> stall = 0, idex_bubble = 1, next sel_a = sel_b = 0, stall_count unchanged.
- Reset/saturation: force 2^CW+3 stalls -> stall_count holds 16'hFFFF. Then assert reset asynchronously mid-stall -> all outputs at reset values before the next edge.
